// File: rtl/tile_loader.sv
// Double-banked row-to-tile assembler: rows fill bank wb while bank rb is presented downstream.
// Optional row_sof framing input is enabled with `define TILE_LOADER_SOF_EN.
module tile_loader #(
  parameter int WIDTH_IN = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_IN-1:0]          row_in,
  input  logic                         row_valid,
`ifdef TILE_LOADER_SOF_EN
  input  logic                         row_sof,
`endif
  output logic                         row_ready,
  output logic [WIDTH_IN*WIDTH_IN-1:0] tile_out,
  output logic                         tile_valid,
  input  logic                         tile_ready,
  output logic [15:0]                  tile_count
);

  localparam int RW = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(WIDTH_IN - 1);

  logic [WIDTH_IN*WIDTH_IN-1:0] bank0;
  logic [WIDTH_IN*WIDTH_IN-1:0] bank1;
  logic                         wb;
  logic                         rb;
  logic                         run;
  logic [RW-1:0]                row_cnt;
  logic [RW-1:0]                wr_row;
  logic [1:0]                   full_cnt;
  logic [15:0]                  tile_count_q;
  logic                         accept;
  logic                         consume;
  logic                         complete;

  // run holds row_ready low while in reset and for no longer than the first edge after it
  assign row_ready  = run & (full_cnt != 2'd2);
  assign tile_valid = (full_cnt != 2'd0);
  assign tile_out   = rb ? bank1 : bank0;
  assign tile_count = tile_count_q;
  assign accept     = row_valid & row_ready;
  assign consume    = tile_valid & tile_ready;

  always_comb begin
    wr_row   = row_cnt;
    complete = accept && (row_cnt == LAST_ROW);
`ifdef TILE_LOADER_SOF_EN
    // a start-of-frame row restarts the tile in bank wb; full_cnt is untouched
    if (row_sof) begin
      wr_row   = '0;
      complete = accept && (WIDTH_IN == 1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0        <= '0;
      bank1        <= '0;
      wb           <= 1'b0;
      rb           <= 1'b0;
      run          <= 1'b0;
      row_cnt      <= '0;
      full_cnt     <= 2'd0;
      tile_count_q <= 16'd0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        for (int r = 0; r < WIDTH_IN; r++) begin
          if (wr_row == RW'(r)) begin
            if (wb) bank1[r*WIDTH_IN +: WIDTH_IN] <= row_in;
            else    bank0[r*WIDTH_IN +: WIDTH_IN] <= row_in;
          end
        end
        if (complete) begin
          row_cnt <= '0;
          wb      <= ~wb;
        end else begin
          row_cnt <= wr_row + RW'(1);
        end
      end
      if (consume) begin
        rb           <= ~rb;
        tile_count_q <= tile_count_q + 16'd1;
      end
      case ({complete, consume})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_loader.sv
// Directed bench for tile_loader at WIDTH_IN = 10 with hand-computed expectations.
// Define TILE_LOADER_SOF_EN for both files to exercise the row_sof path.
module tb_tile_loader;

  localparam int W = 10;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   row_in;
  logic           row_valid;
  logic           row_ready;
  logic [W*W-1:0] tile_out;
  logic           tile_valid;
  logic           tile_ready;
  logic [15:0]    tile_count;
`ifdef TILE_LOADER_SOF_EN
  logic           row_sof;
`endif

  int checks;
  int failures;

  tile_loader #(.WIDTH_IN(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_in     (row_in),
    .row_valid  (row_valid),
`ifdef TILE_LOADER_SOF_EN
    .row_sof    (row_sof),
`endif
    .row_ready  (row_ready),
    .tile_out   (tile_out),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_count (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [W-1:0] d);
    row_in    = d;
    row_valid = 1'b1;
    step();
  endtask

  task automatic do_reset();
    row_valid  = 1'b0;
    tile_ready = 1'b0;
    row_in     = '0;
    rst_n      = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (tile_valid !== 1'b0) begin failures++; $display("FAIL reset_tile_valid got=%b exp=0", tile_valid); end
    checks++; if (tile_out !== '0) begin failures++; $display("FAIL reset_tile_out got=%h exp=0", tile_out); end
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL reset_row_ready got=%b exp=0", row_ready); end
    checks++; if (tile_count !== 16'd0) begin failures++; $display("FAIL reset_tile_count got=%h exp=0", tile_count); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (row_ready !== 1'b1) begin failures++; $display("FAIL post_reset_row_ready got=%b exp=1", row_ready); end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        checks++; if (tile_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", tile_valid); end
      end
      send_row(W'(i));
    end
    row_valid = 1'b0;
    checks++; if (tile_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", tile_valid); end
    checks++; if (tile_out[9:0] !== 10'h000) begin failures++; $display("FAIL single_row0 got=%h exp=000", tile_out[9:0]); end
    checks++; if (tile_out[59:50] !== 10'h005) begin failures++; $display("FAIL single_row5 got=%h exp=005", tile_out[59:50]); end
    checks++; if (tile_out[99:90] !== 10'h009) begin failures++; $display("FAIL single_row9 got=%h exp=009", tile_out[99:90]); end
    step(); step();
    checks++; if (tile_valid !== 1'b1 || tile_out[99:90] !== 10'h009) begin failures++; $display("FAIL single_hold got=%b/%h exp=1/009", tile_valid, tile_out[99:90]); end
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", tile_valid); end
    checks++; if (tile_count !== 16'd1) begin failures++; $display("FAIL single_count got=%h exp=1", tile_count); end
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_count !== 16'd1) begin failures++; $display("FAIL idle_ready_ignored got=%h exp=1", tile_count); end
  endtask

  task automatic test_backpressure();
    int drops;
    drops = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (row_ready !== 1'b1) drops++;
      send_row(W'(10'h100 + i));
    end
    checks++; if (drops !== 0) begin failures++; $display("FAIL bp_early_drops got=%0d exp=0", drops); end
    row_in = 10'h114;
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", row_ready); end
    checks++; if (tile_out[9:0] !== 10'h100 || tile_out[99:90] !== 10'h109) begin failures++; $display("FAIL bp_first_tile got=%h/%h exp=100/109", tile_out[9:0], tile_out[99:90]); end
    step(); step();
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", row_ready); end
    tile_ready = 1'b1;
    #1;
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_same_cycle got=%b exp=0", row_ready); end
    step();
    tile_ready = 1'b0;
    checks++; if (row_ready !== 1'b1) begin failures++; $display("FAIL bp_resume got=%b exp=1", row_ready); end
    checks++; if (tile_out[9:0] !== 10'h10A || tile_out[99:90] !== 10'h113) begin failures++; $display("FAIL bp_second_tile got=%h/%h exp=10a/113", tile_out[9:0], tile_out[99:90]); end
    checks++; if (tile_count !== 16'd1) begin failures++; $display("FAIL bp_count got=%h exp=1", tile_count); end
    for (int i = 20; i < 25; i++) send_row(W'(10'h100 + i));
    row_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (tile_out[9:0] !== 10'h10A || tile_valid !== 1'b1) begin failures++; $display("FAIL bp_stable got=%h/%b exp=10a/1", tile_out[9:0], tile_valid); end
    for (int i = 25; i < 30; i++) send_row(W'(10'h100 + i));
    row_valid  = 1'b0;
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_out[9:0] !== 10'h114 || tile_out[59:50] !== 10'h119 || tile_out[99:90] !== 10'h11D) begin
      failures++; $display("FAIL bp_partial_kept got=%h/%h/%h exp=114/119/11d", tile_out[9:0], tile_out[59:50], tile_out[99:90]);
    end
  endtask

  task automatic test_back_to_back();
    int drops;
    drops = 0;
    do_reset();
    tile_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (row_ready !== 1'b1) drops++;
      send_row(W'(i));
    end
    row_valid = 1'b0;
    checks++; if (drops !== 0) begin failures++; $display("FAIL b2b_drops got=%0d exp=0", drops); end
    checks++; if (tile_valid !== 1'b1 || tile_out[9:0] !== 10'd20) begin failures++; $display("FAIL b2b_third_tile got=%b/%h exp=1/014", tile_valid, tile_out[9:0]); end
    step();
    tile_ready = 1'b0;
    checks++; if (tile_count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%h exp=3", tile_count); end
    checks++; if (tile_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", tile_valid); end
  endtask

  task automatic test_same_edge();
    do_reset();
    for (int i = 0; i < 10; i++) send_row(W'(10'h040 + i));
    for (int i = 10; i < 19; i++) send_row(W'(10'h040 + i));
    tile_ready = 1'b1;
    send_row(10'h053);
    row_valid  = 1'b0;
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b1 || row_ready !== 1'b1) begin failures++; $display("FAIL same_edge_flags got=%b/%b exp=1/1", tile_valid, row_ready); end
    checks++; if (tile_out[9:0] !== 10'h04A || tile_out[99:90] !== 10'h053) begin failures++; $display("FAIL same_edge_tile got=%h/%h exp=04a/053", tile_out[9:0], tile_out[99:90]); end
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b0 || tile_count !== 16'd2) begin failures++; $display("FAIL same_edge_drain got=%b/%h exp=0/2", tile_valid, tile_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 15; i++) send_row(W'(10'h200 + i));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tile_valid !== 1'b0 || row_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", tile_valid, row_ready); end
    checks++; if (tile_out !== '0) begin failures++; $display("FAIL rst_mid_tile_out got=%h exp=0", tile_out); end
    row_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) send_row(W'(10'h300 + i));
    row_valid = 1'b0;
    checks++; if (tile_out[9:0] !== 10'h300 || tile_out[49:40] !== 10'h304 || tile_out[99:90] !== 10'h309) begin
      failures++; $display("FAIL rst_mid_new_tile got=%h/%h/%h exp=300/304/309", tile_out[9:0], tile_out[49:40], tile_out[99:90]);
    end
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b0 || tile_count !== 16'd1) begin failures++; $display("FAIL rst_mid_one_tile got=%b/%h exp=0/1", tile_valid, tile_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    force dut.tile_count_q = 16'hFFFF;
    #1;
    release dut.tile_count_q;
    #1;
    checks++; if (tile_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", tile_count); end
    for (int i = 0; i < 10; i++) send_row(W'(i));
    row_valid  = 1'b0;
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", tile_count); end
  endtask

`ifdef TILE_LOADER_SOF_EN
  task automatic test_sof();
    do_reset();
    for (int i = 0; i < 4; i++) send_row(W'(10'h3A0 + i));
    row_sof = 1'b1;
    send_row(10'h155);
    row_sof = 1'b0;
    for (int i = 1; i < 10; i++) send_row(W'(10'h150 + i));
    row_valid = 1'b0;
    checks++; if (tile_valid !== 1'b1) begin failures++; $display("FAIL sof_valid got=%b exp=1", tile_valid); end
    checks++; if (tile_out[9:0] !== 10'h155 || tile_out[19:10] !== 10'h151 || tile_out[99:90] !== 10'h159) begin
      failures++; $display("FAIL sof_tile got=%h/%h/%h exp=155/151/159", tile_out[9:0], tile_out[19:10], tile_out[99:90]);
    end
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin failures++; $display("FAIL sof_single got=%b exp=0", tile_valid); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    row_valid  = 1'b0;
    row_in     = '0;
    tile_ready = 1'b0;
`ifdef TILE_LOADER_SOF_EN
    row_sof    = 1'b0;
`endif
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
    test_wrap();
`ifdef TILE_LOADER_SOF_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
